// File: rtl/selectmap_cfg_master.sv
// ============================================================================
// Module   : selectmap_cfg_master
// Purpose  : SelectMAP (8-bit, write-only) configuration master. Pulses
//            PROG_B, waits for INIT_B, streams bitstream bytes on SMAP_D
//            under a divided CCLK and runs startup clocks until DONE.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   CCLK_DIV          CLK cycles per CCLK half-period (2..255)
//   PROG_PULSE_CYCLES PROG_B low time in CLK cycles
//   INIT_TIMEOUT      max CLK cycles waiting for INIT_B high
//   DONE_TIMEOUT      max CCLK rising edges in STARTUP before error
// Ports
//   clk, rst_b                 clock, asynchronous active-low reset
//   start                      one-cycle pulse, begins configuration
//   data_in/valid/last/ready   bitstream byte stream (valid/ready handshake)
//   prog_b                     FPGA PROG_B (active low)
//   init_b, fpga_busy_b,
//   fpga_done                  FPGA status inputs (asynchronous)
//   cclk, fpga_cs_b,
//   fpga_rdwr_b, smap_d        SelectMAP bus
//   cfg_done, cfg_err,
//   err_code                   status: 1=INIT timeout, 2=DONE timeout,
//                              3=INIT_B low during LOAD
// Build option
//   SMAP_BITSWAP_EN            when defined, smap_d[i] = data_in[7-i]
// ============================================================================
`default_nettype none

module selectmap_cfg_master #(
  parameter int CCLK_DIV          = 2,
  parameter int PROG_PULSE_CYCLES = 64,
  parameter int INIT_TIMEOUT      = 65535,
  parameter int DONE_TIMEOUT      = 4096
) (
  input  logic       clk,
  input  logic       rst_b,
  input  logic       start,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  input  logic       data_last,
  output logic       data_ready,
  output logic       prog_b,
  input  logic       init_b,
  input  logic       fpga_busy_b,
  input  logic       fpga_done,
  output logic       cclk,
  output logic       fpga_cs_b,
  output logic       fpga_rdwr_b,
  output logic [7:0] smap_d,
  output logic       cfg_done,
  output logic       cfg_err,
  output logic [1:0] err_code
);

  localparam int c_WAIT_MAX = (PROG_PULSE_CYCLES > INIT_TIMEOUT) ? PROG_PULSE_CYCLES : INIT_TIMEOUT;
  localparam int c_WAIT_W   = $clog2(c_WAIT_MAX + 1);
  localparam int c_DIV_W    = $clog2(CCLK_DIV);
  localparam int c_EDGE_W   = $clog2(DONE_TIMEOUT + 1);

  localparam logic [c_WAIT_W-1:0] c_PROG_LAST = c_WAIT_W'(PROG_PULSE_CYCLES - 1);
  localparam logic [c_WAIT_W-1:0] c_INIT_LAST = c_WAIT_W'(INIT_TIMEOUT - 1);
  localparam logic [c_DIV_W-1:0]  c_DIV_LAST  = c_DIV_W'(CCLK_DIV - 1);
  localparam logic [c_EDGE_W-1:0] c_EDGE_MAX  = c_EDGE_W'(DONE_TIMEOUT);
  localparam logic [3:0]          c_POST_EDGES = 4'd8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PROG      = 3'd1,
    INIT_WAIT = 3'd2,
    LOAD      = 3'd3,
    STARTUP   = 3'd4,
    DONE_ST   = 3'd5,
    ERR_ST    = 3'd6
  } state_t;

  state_t r_state, w_next;
  logic [1:0] w_next_code;

  // Two-flop synchronizers; _B inputs idle high, DONE idles low.
  logic r_init_s1, r_init_s2, r_busy_s1, r_busy_s2, r_done_s1, r_done_s2;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_init_s1 <= 1'b1; r_init_s2 <= 1'b1;
      r_busy_s1 <= 1'b1; r_busy_s2 <= 1'b1;
      r_done_s1 <= 1'b0; r_done_s2 <= 1'b0;
    end else begin
      r_init_s1 <= init_b;      r_init_s2 <= r_init_s1;
      r_busy_s1 <= fpga_busy_b; r_busy_s2 <= r_busy_s1;
      r_done_s1 <= fpga_done;   r_done_s2 <= r_done_s1;
    end
  end

  logic [c_WAIT_W-1:0] r_wait_cnt;
  logic [c_DIV_W-1:0]  r_div_cnt;
  logic [c_EDGE_W-1:0] r_edge_cnt;
  logic [3:0]          r_post_cnt;
  logic                r_done_seen;
  logic                r_cclk, r_cs_b, r_prog_b;
  logic [7:0]          r_smap_d;
  logic                r_byte_valid, r_byte_last, r_last_taken;
  logic                r_cfg_done, r_cfg_err;
  logic [1:0]          r_err_code;
  logic [7:0]          w_data_ordered;

`ifdef SMAP_BITSWAP_EN
  generate
    for (genvar i = 0; i < 8; i++) begin : g_bitswap
      assign w_data_ordered[i] = data_in[7-i];
    end
  endgenerate
`else
  assign w_data_ordered = data_in;
`endif

  // CCLK phase events. The divider holds at its terminal count while
  // stalled, so w_tick stays asserted until a byte arrives.
  logic w_tick, w_fall, w_rise, w_load_err, w_accept, w_consume, w_done_now;

  assign w_tick     = (r_div_cnt == c_DIV_LAST);
  assign w_fall     = w_tick && r_cclk;
  assign w_load_err = (r_state == LOAD) && !r_init_s2;
  assign w_rise     = w_tick && !r_cclk &&
                      ((r_state == STARTUP) ||
                       ((r_state == LOAD) && r_byte_valid && !w_load_err));
  assign data_ready = (r_state == LOAD) && !w_load_err && !r_byte_valid &&
                      !r_last_taken && w_tick;
  assign w_accept   = data_ready && data_valid;
  assign w_consume  = (r_state == LOAD) && w_rise && !r_cs_b && r_busy_s2;
  assign w_done_now = r_done_seen || r_done_s2;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Phase changes that affect the bus (LOAD->STARTUP, STARTUP->DONE/ERR)
  // happen on a CCLK falling slot so CS_B never moves with a rising edge.
  always_comb begin
    w_next      = r_state;
    w_next_code = 2'd0;
    case (r_state)
      IDLE, DONE_ST, ERR_ST: if (start) w_next = PROG;
      PROG:      if (r_wait_cnt == c_PROG_LAST) w_next = INIT_WAIT;
      INIT_WAIT: begin
        if (r_init_s2) w_next = LOAD;
        else if (r_wait_cnt == c_INIT_LAST) begin
          w_next      = ERR_ST;
          w_next_code = 2'd1;
        end
      end
      LOAD: begin
        if (w_load_err) begin
          w_next      = ERR_ST;
          w_next_code = 2'd3;
        end else if (w_fall && r_last_taken) begin
          w_next = STARTUP;
        end
      end
      STARTUP: begin
        if (w_fall) begin
          if (r_post_cnt == c_POST_EDGES) w_next = DONE_ST;
          else if (!w_done_now && (r_edge_cnt >= c_EDGE_MAX)) begin
            w_next      = ERR_ST;
            w_next_code = 2'd2;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_wait_cnt   <= '0;
      r_div_cnt    <= '0;
      r_edge_cnt   <= '0;
      r_post_cnt   <= '0;
      r_done_seen  <= 1'b0;
      r_cclk       <= 1'b0;
      r_cs_b       <= 1'b1;
      r_prog_b     <= 1'b1;
      r_smap_d     <= 8'hFF;
      r_byte_valid <= 1'b0;
      r_byte_last  <= 1'b0;
      r_last_taken <= 1'b0;
      r_cfg_done   <= 1'b0;
      r_cfg_err    <= 1'b0;
      r_err_code   <= 2'd0;
    end else begin
      r_prog_b <= (w_next != PROG);
      r_cs_b   <= (w_next != LOAD);

      if ((w_next != r_state) || !((r_state == PROG) || (r_state == INIT_WAIT)))
        r_wait_cnt <= '0;
      else
        r_wait_cnt <= r_wait_cnt + 1'b1;

      if ((w_next == LOAD) || (w_next == STARTUP)) begin
        if (w_tick) begin
          if (r_cclk) begin
            r_cclk    <= 1'b0;
            r_div_cnt <= '0;
          end else if (w_rise) begin
            r_cclk    <= 1'b1;
            r_div_cnt <= '0;
          end else if (w_accept) begin
            // Byte arrived during a stall: give it a full low half-period.
            r_div_cnt <= '0;
          end
        end else begin
          r_div_cnt <= r_div_cnt + 1'b1;
        end
      end else begin
        r_cclk    <= 1'b0;
        r_div_cnt <= '0;
      end

      if (w_next != LOAD) begin
        r_byte_valid <= 1'b0;
        r_byte_last  <= 1'b0;
        r_last_taken <= 1'b0;
        r_smap_d     <= 8'hFF;
      end else if (w_accept) begin
        r_byte_valid <= 1'b1;
        r_byte_last  <= data_last;
        r_smap_d     <= w_data_ordered;
      end else if (w_consume) begin
        r_byte_valid <= 1'b0;
        if (r_byte_last) r_last_taken <= 1'b1;
      end

      if (r_state == STARTUP) begin
        if (r_done_s2) r_done_seen <= 1'b1;
        if (w_rise) begin
          if (r_edge_cnt != c_EDGE_MAX) r_edge_cnt <= r_edge_cnt + 1'b1;
          if (w_done_now && (r_post_cnt != c_POST_EDGES)) r_post_cnt <= r_post_cnt + 1'b1;
        end
      end else begin
        r_edge_cnt  <= '0;
        r_post_cnt  <= '0;
        r_done_seen <= 1'b0;
      end

      if ((r_state inside {IDLE, DONE_ST, ERR_ST}) && (w_next == PROG)) begin
        r_cfg_done <= 1'b0;
        r_cfg_err  <= 1'b0;
        r_err_code <= 2'd0;
      end else if ((r_state == STARTUP) && (w_next == DONE_ST)) begin
        r_cfg_done <= 1'b1;
      end else if ((r_state != ERR_ST) && (w_next == ERR_ST)) begin
        r_cfg_err  <= 1'b1;
        r_err_code <= w_next_code;
      end
    end
  end

  assign prog_b      = r_prog_b;
  assign cclk        = r_cclk;
  assign fpga_cs_b   = r_cs_b;
  assign fpga_rdwr_b = 1'b0;
  assign smap_d      = r_smap_d;
  assign cfg_done    = r_cfg_done;
  assign cfg_err     = r_cfg_err;
  assign err_code    = r_err_code;

endmodule

`default_nettype wire

// File: doc/selectmap_cfg_master.md
SELECTMAP_CFG_MASTER -- requirements
Module: selectmap_cfg_master

Interface
REQ-001 Parameter CCLK_DIV, default 2, meaning CLK cycles per CCLK half-period (legal range 2..255).
REQ-002 Parameter PROG_PULSE_CYCLES, default 64, meaning PROG_B low time in CLK cycles.
REQ-003 Parameter INIT_TIMEOUT, default 65535, meaning max CLK cycles waiting for INIT_B high.
REQ-004 Parameter DONE_TIMEOUT, default 4096, meaning max CCLK rising edges in STARTUP before error.
REQ-005 CLK  in  1  single clock for all logic.
REQ-006 RST_B  in  1  asynchronous active-low reset.
REQ-007 START  in  1  one-CLK pulse, begins configuration.
REQ-008 DATA_IN  in  8  bitstream byte.
REQ-009 DATA_VALID  in  1  DATA_IN valid.
REQ-010 DATA_LAST  in  1  qualifies the final byte, valid with DATA_VALID.
REQ-011 DATA_READY  out  1  byte accepted when DATA_VALID and DATA_READY are both high.
REQ-012 PROG_B  out  1  FPGA program, active low.
REQ-013 INIT_B  in  1  FPGA INIT_B, asynchronous.
REQ-014 FPGA_BUSY_B  in  1  FPGA busy, active low, asynchronous.
REQ-015 FPGA_DONE  in  1  FPGA DONE, asynchronous.
REQ-016 CCLK  out  1  configuration clock.
REQ-017 FPGA_CS_B  out  1  SelectMAP chip select, active low.
REQ-018 FPGA_RDWR_B  out  1  SelectMAP direction; constant 0 (write).
REQ-019 SMAP_D  out  8  SelectMAP data bus.
REQ-020 CFG_DONE  out  1  configuration complete, held until next START.
REQ-021 CFG_ERR  out  1  configuration failed, held until next START.
REQ-022 ERR_CODE  out  2  1=INIT timeout, 2=DONE timeout, 3=INIT_B low during LOAD; 0 otherwise.

Function
REQ-023 INIT_B, FPGA_BUSY_B and FPGA_DONE SHALL each pass through a 2-flop synchronizer before use.
REQ-024 FSM states SHALL be IDLE, PROG, INIT_WAIT, LOAD, STARTUP, DONE_ST, ERR_ST.
REQ-025 IDLE/DONE_ST/ERR_ST: START SHALL go to PROG, clearing CFG_DONE, CFG_ERR and ERR_CODE.
REQ-026 PROG: PROG_B low for exactly PROG_PULSE_CYCLES CLK cycles, then INIT_WAIT with PROG_B high.
REQ-027 INIT_WAIT: synchronized INIT_B high SHALL go to LOAD; INIT_TIMEOUT cycles without it SHALL go to ERR_ST with ERR_CODE=1.
REQ-028 CCLK SHALL toggle every CCLK_DIV CLK cycles only in LOAD and STARTUP, and SHALL be low in all other states.
REQ-029 LOAD: FPGA_CS_B low; SMAP_D SHALL change only while CCLK is low, at the CCLK falling-edge CLK cycle.
REQ-030 A byte is consumed at a CCLK rising edge only if CS_B is low, a byte is loaded, and synchronized FPGA_BUSY_B is high; otherwise the same byte SHALL be repeated.
REQ-031 DATA_READY SHALL be high for one CLK cycle at each CCLK falling edge in LOAD when no byte is held.
REQ-032 If no byte is available at a CCLK falling edge, CCLK SHALL hold low (stall) until one is, with no spurious rising edge.
REQ-033 After the DATA_LAST byte is consumed, the FSM SHALL go to STARTUP with FPGA_CS_B high and SMAP_D=8'hFF.
REQ-034 STARTUP: CCLK SHALL continue until synchronized FPGA_DONE is high, plus 8 further rising edges, then DONE_ST with CFG_DONE=1.
REQ-035 STARTUP: DONE_TIMEOUT rising edges without DONE SHALL go to ERR_ST with ERR_CODE=2.
REQ-036 LOAD: synchronized INIT_B low SHALL go to ERR_ST with ERR_CODE=3, taking priority over a simultaneous byte transfer.
REQ-037 START SHALL be ignored in PROG, INIT_WAIT, LOAD and STARTUP.
REQ-038 ERR_ST SHALL drive FPGA_CS_B high, CCLK low and CFG_ERR=1.

Reset
REQ-039 On RST_B low: state IDLE, PROG_B=1, CCLK=0, FPGA_CS_B=1, FPGA_RDWR_B=0, SMAP_D=8'hFF, DATA_READY=0, CFG_DONE=0, CFG_ERR=0, ERR_CODE=0, and all counters and synchronizers cleared, with synchronizers cleared to 1 for the _B inputs and 0 for FPGA_DONE.
REQ-040 Reset asserted mid-LOAD SHALL abandon the transfer immediately; no partial-byte recovery.

Configuration
REQ-041 Macro SMAP_BITSWAP_EN defined: SMAP_D[i] SHALL equal DATA_IN[7-i] (Xilinx SelectMAP bit order); undefined: SMAP_D SHALL equal DATA_IN unchanged.

Verification
REQ-042 START, INIT_B rises 10 cycles after PROG_B release, bytes 8'h12,8'h34 with LAST on the second, DONE rises after 3 STARTUP edges -> SMAP_D carries exactly 2 bytes, then 8 edges after DONE, CFG_DONE=1.
REQ-043 FPGA_BUSY_B low across one rising edge during byte 8'hA5 -> 8'hA5 is presented for two rising edges and the byte count is unchanged.
REQ-044 INIT_B held low after PROG -> ERR_CODE=1 and CFG_ERR=1 after INIT_TIMEOUT cycles, with CCLK never toggling.
REQ-045 INIT_B driven low mid-LOAD -> ERR_ST, ERR_CODE=3, FPGA_CS_B=1 within 3 CLK cycles.
REQ-046 DATA_VALID gap of 20 cycles -> CCLK holds low with no extra rising edge; with SMAP_BITSWAP_EN defined, DATA_IN 8'h01 appears on SMAP_D as 8'h80.
